// File: rtl/cache_pkg.sv
// Shared widths, FSM encoding and address helpers for the direct-mapped instruction cache.
package cache_pkg;

   localparam int WORD_SIZE  = 16;
   localparam int LINE_WORDS = 4;
   localparam int NUM_LINES  = 4;
   localparam int OFFSET_W   = $clog2(LINE_WORDS);
   localparam int INDEX_W    = $clog2(NUM_LINES);
   localparam int TAG_W      = WORD_SIZE - OFFSET_W - INDEX_W;
   localparam int CNT_W      = 16;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_t;

   // Line-aligned address: the offset bits forced to zero.
   function automatic logic [WORD_SIZE-1:0] line_base(input logic [WORD_SIZE-1:0] addr);
      return {addr[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/icache_line_store.sv
// Data/tag/valid storage for the instruction cache: combinational read, word-wise fill write,
// single-cycle invalidate of every line. Only the valid bits are reset.
module icache_line_store
   import cache_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic [INDEX_W-1:0]   rd_index,
   input  logic [OFFSET_W-1:0]  rd_offset,
   output logic [WORD_SIZE-1:0] rd_data,
   output logic [TAG_W-1:0]     rd_tag,
   output logic                 rd_valid,
   input  logic                 wr_en,
   input  logic [INDEX_W-1:0]   wr_index,
   input  logic [OFFSET_W-1:0]  wr_offset,
   input  logic [WORD_SIZE-1:0] wr_data,
   input  logic                 tag_wr_en,
   input  logic [TAG_W-1:0]     tag_wr_data,
   input  logic                 set_valid,
   input  logic                 inv_all
);

   logic [WORD_SIZE-1:0] data_mem [0:NUM_LINES-1][0:LINE_WORDS-1];
   logic [TAG_W-1:0]     tag_mem  [0:NUM_LINES-1];
   logic [NUM_LINES-1:0] valid_q;

   assign rd_data  = data_mem[rd_index][rd_offset];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_valid = valid_q[rd_index];

   always_ff @(posedge Clk) begin
      if (wr_en) data_mem[wr_index][wr_offset] <= wr_data;
      if (tag_wr_en) tag_mem[wr_index] <= tag_wr_data;
   end

   // Invalidate takes priority over a line completing in the same cycle.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N)       valid_q <= '0;
      else if (inv_all)   valid_q <= '0;
      else if (set_valid) valid_q[wr_index] <= 1'b1;
   end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, stall on miss,
// word-serial line fill from instruction memory, and hit/miss statistics.
module instruction_cache
   import cache_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Reset_N,
   input  logic                 ReadReq,
   input  logic [WORD_SIZE-1:0] PCIn,
   input  logic                 InvalidateAll,
   output logic [WORD_SIZE-1:0] InstructionOut,
   output logic                 InstCacheMiss,
   output logic                 MemReq,
   output logic [WORD_SIZE-1:0] MemAddr,
   input  logic                 MemValid,
   input  logic [WORD_SIZE-1:0] MemData,
   output logic [CNT_W-1:0]     HitCount,
   output logic [CNT_W-1:0]     MissCount
);

   fill_state_t          state, state_nxt;
   logic [OFFSET_W-1:0]  fill_cnt;
   logic                 discard;

   logic [OFFSET_W-1:0]  pc_offset;
   logic [INDEX_W-1:0]   pc_index;
   logic [TAG_W-1:0]     pc_tag;
   logic [INDEX_W-1:0]   fill_index;
   logic [TAG_W-1:0]     fill_tag;

   logic [WORD_SIZE-1:0] rd_data;
   logic [TAG_W-1:0]     rd_tag;
   logic                 rd_valid;

   logic                 hit;
   logic                 start_fill;
   logic                 fill_beat;
   logic                 fill_last;

   assign pc_offset  = PCIn[OFFSET_W-1:0];
   assign pc_index   = PCIn[OFFSET_W +: INDEX_W];
   assign pc_tag     = PCIn[WORD_SIZE-1 -: TAG_W];
   assign fill_index = MemAddr[OFFSET_W +: INDEX_W];
   assign fill_tag   = MemAddr[WORD_SIZE-1 -: TAG_W];

   // Lookups are only honoured in IDLE so a half-written line is never served.
   assign hit        = (state == IDLE) && rd_valid && (rd_tag == pc_tag);
   assign start_fill = (state == IDLE) && ReadReq && !hit;
   assign fill_beat  = (state == FILL) && MemValid;
   assign fill_last  = fill_beat && (fill_cnt == OFFSET_W'(LINE_WORDS - 1));

   icache_line_store u_line_store (
      .Clk         (Clk),
      .Reset_N     (Reset_N),
      .rd_index    (pc_index),
      .rd_offset   (pc_offset),
      .rd_data     (rd_data),
      .rd_tag      (rd_tag),
      .rd_valid    (rd_valid),
      .wr_en       (fill_beat),
      .wr_index    (fill_index),
      .wr_offset   (fill_cnt),
      .wr_data     (MemData),
      .tag_wr_en   (fill_last),
      .tag_wr_data (fill_tag),
      .set_valid   (fill_last && !discard && !InvalidateAll),
      .inv_all     (InvalidateAll)
   );

   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_fill) state_nxt = FILL;
         FILL:    if (fill_last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      MemReq         = (state == FILL);
      InstCacheMiss  = ReadReq && !hit;
      InstructionOut = (ReadReq && hit) ? rd_data : '0;
   end

   // An invalidate seen mid-fill must also cover the line still being filled.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         fill_cnt  <= '0;
         discard   <= 1'b0;
         MemAddr   <= '0;
         HitCount  <= '0;
         MissCount <= '0;
      end else begin
         if (start_fill) begin
            fill_cnt  <= '0;
            discard   <= 1'b0;
            MemAddr   <= line_base(PCIn);
            MissCount <= MissCount + 1'b1;
         end else begin
            if (fill_beat) fill_cnt <= fill_cnt + 1'b1;
            if ((state == FILL) && InvalidateAll) discard <= 1'b1;
         end
         if (ReadReq && hit) HitCount <= HitCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed scenarios plus randomized traffic against a line-level model.
module tb_instruction_cache;
   import cache_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset_N = 1'b0;
   logic        ReadReq = 1'b0;
   logic [15:0] PCIn = 16'h0;
   logic        InvalidateAll = 1'b0;
   logic [15:0] InstructionOut;
   logic        InstCacheMiss;
   logic        MemReq;
   logic [15:0] MemAddr;
   logic        MemValid = 1'b0;
   logic [15:0] MemData = 16'h0;
   logic [15:0] HitCount;
   logic [15:0] MissCount;

   instruction_cache dut (
      .Clk            (Clk),
      .Reset_N        (Reset_N),
      .ReadReq        (ReadReq),
      .PCIn           (PCIn),
      .InvalidateAll  (InvalidateAll),
      .InstructionOut (InstructionOut),
      .InstCacheMiss  (InstCacheMiss),
      .MemReq         (MemReq),
      .MemAddr        (MemAddr),
      .MemValid       (MemValid),
      .MemData        (MemData),
      .HitCount       (HitCount),
      .MissCount      (MissCount)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_pass   = 0;

   logic [15:0] mem [0:255];
   int  resp_prob = 100;
   bit  spur_en   = 1'b0;
   int  resp_cnt  = 0;
   bit  drove_real = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   task automatic wait_fill(input string name);
      int n = 0;
      while (MemReq && n < 40) begin
         tick();
         n++;
      end
      check(name, MemReq, 1'b0);
   endtask

   // Instruction memory: serves words of the requested line in order, optionally injects stray beats.
   always @(posedge Clk) begin
      logic [7:0] a;
      #1;
      if (!Reset_N) begin
         resp_cnt   = 0;
         drove_real = 1'b0;
         MemValid   = 1'b0;
         MemData    = 16'h0;
      end else begin
         if (drove_real) resp_cnt = (resp_cnt + 1) % LINE_WORDS;
         drove_real = 1'b0;
         MemValid   = 1'b0;
         MemData    = 16'($urandom);
         if (MemReq) begin
            if ($urandom_range(99) < resp_prob) begin
               a          = MemAddr[7:0] + 8'(resp_cnt);
               MemValid   = 1'b1;
               MemData    = mem[a];
               drove_real = 1'b1;
            end
         end else if (spur_en && $urandom_range(3) == 0) begin
            MemValid = 1'b1;
            MemData  = 16'hdead;
         end
      end
   end

   // Reference model: cache contents per line, plus an outstanding-fill record.
   bit          m_valid [4];
   logic [11:0] m_tag   [4];
   logic [15:0] m_data  [4][4];
   bit          m_busy;
   logic [15:0] m_addr;
   int          m_got;
   bit          m_disc;
   logic [15:0] m_hits, m_misses;

   always @(negedge Clk) begin
      logic [1:0]  idx, off, fi;
      logic [11:0] tg;
      bit          hit;
      if (!Reset_N) begin
         for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
         m_busy = 1'b0; m_addr = 16'h0; m_got = 0; m_disc = 1'b0;
         m_hits = 16'h0; m_misses = 16'h0;
      end
      idx = PCIn[3:2];
      off = PCIn[1:0];
      tg  = PCIn[15:4];
      hit = !m_busy && m_valid[idx] && (m_tag[idx] == tg);
      check("cmp_out", InstructionOut, (ReadReq && hit) ? m_data[idx][off] : 16'h0);
      check("cmp_miss", InstCacheMiss, ReadReq && !hit);
      check("cmp_memreq", MemReq, m_busy);
      check("cmp_memaddr", MemAddr, m_addr);
      check("cmp_hits", HitCount, m_hits);
      check("cmp_misses", MissCount, m_misses);
      if (Reset_N) begin
         if (!m_busy) begin
            if (ReadReq && hit) m_hits++;
            else if (ReadReq) begin
               m_misses++;
               m_busy = 1'b1;
               m_addr = {PCIn[15:2], 2'b00};
               m_got  = 0;
               m_disc = 1'b0;
            end
            if (InvalidateAll) for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
         end else begin
            if (InvalidateAll) begin
               for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
               m_disc = 1'b1;
            end
            if (MemValid) begin
               fi = m_addr[3:2];
               m_data[fi][m_got] = MemData;
               m_got++;
               if (m_got == 4) begin
                  m_tag[fi] = m_addr[15:4];
                  if (!m_disc) m_valid[fi] = 1'b1;
                  m_busy = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[4] = 16'h1111; mem[5] = 16'h2222; mem[6] = 16'h3333; mem[7] = 16'h4444;

      repeat (3) tick();
      check("rst_hitcnt", HitCount, 16'h0);
      check("rst_misscnt", MissCount, 16'h0);
      check("rst_memreq", MemReq, 1'b0);
      check("rst_memaddr", MemAddr, 16'h0);
      check("rst_stall", InstCacheMiss, 1'b0);
      Reset_N = 1'b1;

      // cold miss
      ReadReq = 1'b1; PCIn = 16'h0005; #1;
      check("cold_miss", InstCacheMiss, 1'b1);
      check("cold_noreq_yet", MemReq, 1'b0);
      tick();
      check("cold_memreq", MemReq, 1'b1);
      check("cold_memaddr", MemAddr, 16'h0004);
      check("cold_stall", InstCacheMiss, 1'b1);
      wait_fill("cold_fill_done");
      check("cold_data", InstructionOut, 16'h2222);
      check("cold_nomiss", InstCacheMiss, 1'b0);
      check("cold_misscnt", MissCount, 16'd1);

      // same-line hit
      PCIn = 16'h0007; #1;
      check("hit_data", InstructionOut, 16'h4444);
      check("hit_nomiss", InstCacheMiss, 1'b0);
      check("hit_noreq", MemReq, 1'b0);
      tick();
      check("hit_cnt", HitCount, 16'd1);

      // conflict eviction
      PCIn = 16'h0014; #1;
      check("conf_miss", InstCacheMiss, 1'b1);
      tick();
      check("conf_memaddr", MemAddr, 16'h0014);
      wait_fill("conf_fill_done");
      PCIn = 16'h0005; #1;
      check("conf_remiss", InstCacheMiss, 1'b1);
      tick();
      wait_fill("conf_refill_done");
      check("conf_misscnt", MissCount, 16'd3);
      check("conf_data", InstructionOut, 16'h2222);

      // PC change mid-fill
      ReadReq = 1'b0; InvalidateAll = 1'b1;
      tick();
      InvalidateAll = 1'b0; ReadReq = 1'b1; PCIn = 16'h0004; #1;
      check("mid_miss", InstCacheMiss, 1'b1);
      tick(); tick(); tick();
      PCIn = 16'h0020;
      wait_fill("mid_fill_done");
      check("mid_addr_held", MemAddr, 16'h0004);
      check("mid_stall", InstCacheMiss, 1'b1);
      tick();
      check("mid_newreq", MemReq, 1'b1);
      check("mid_newaddr", MemAddr, 16'h0020);
      wait_fill("mid_newfill_done");
      PCIn = 16'h0004; #1;
      check("mid_old_line", InstructionOut, 16'h1111);

      // invalidate coincident with last fill word
      PCIn = 16'h0030; #1;
      tick(); tick(); tick(); tick();
      InvalidateAll = 1'b1;
      tick();
      InvalidateAll = 1'b0; #1;
      check("inv_noreq", MemReq, 1'b0);
      check("inv_remiss", InstCacheMiss, 1'b1);
      tick();
      check("inv_refill", MemReq, 1'b1);
      check("inv_addr", MemAddr, 16'h0030);

      // asynchronous reset mid-fill
      tick();
      Reset_N = 1'b0; #1;
      check("rstf_memreq", MemReq, 1'b0);
      check("rstf_hitcnt", HitCount, 16'h0);
      check("rstf_misscnt", MissCount, 16'h0);
      check("rstf_memaddr", MemAddr, 16'h0);
      tick(); tick();
      Reset_N = 1'b1;

      // stray MemValid while idle
      PCIn = 16'h0041; #1;
      tick();
      wait_fill("sp_fill_done");
      check("sp_first", InstructionOut, mem[8'h41]);
      ReadReq = 1'b0; spur_en = 1'b1;
      repeat (8) tick();
      spur_en = 1'b0;
      tick();
      ReadReq = 1'b1; #1;
      check("sp_keep", InstructionOut, mem[8'h41]);
      check("sp_nomiss", InstCacheMiss, 1'b0);

      // randomized traffic
      resp_prob = 60; spur_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         ReadReq = ($urandom_range(9) < 8);
         if (!InstCacheMiss || $urandom_range(3) == 0) PCIn = 16'($urandom_range(127));
         InvalidateAll = ($urandom_range(39) == 0);
         tick();
      end
      ReadReq = 1'b0; InvalidateAll = 1'b0; spur_en = 1'b0;
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
